izh_sweep_scheduler: RTL and testbench

Time-multiplexes one shared Izhikevich update datapath across N_NEURONS neurons. Holds per-neuron state (v, u), type code and input current. On each timestep tick it sweeps all neurons in index order: it issues each neuron's operands over a req/ack handshake, writes back the results and reports spikes. It sits between the host configuration pins and the single-neuron update engine.

---
 rtl/izh_pkg.sv | 28 ++
 rtl/izh_state_table.sv | 71 +++++++
 rtl/izh_sweep_scheduler.sv | 167 ++++++++++++++++
 tb/tb_izh_sweep_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared definitions for the Izhikevich sweep scheduler.
//   W              : state width, signed 2.16 fixed point
//   V_RST / U_RST  : power-on membrane state (-0.7 / -0.2)
//   TYPE_*         : neuron type codes presented to the datapath
//   state_e        : sweep scheduler FSM states
package izh_pkg;

  localparam int unsigned W = 18;

  localparam logic signed [W-1:0] V_RST = 18'sh3_4CCD;
  localparam logic signed [W-1:0] U_RST = 18'sh3_CCCD;

  localparam logic [3:0] TYPE_RS  = 4'd0;
  localparam logic [3:0] TYPE_IB  = 4'd1;
  localparam logic [3:0] TYPE_CH  = 4'd2;
  localparam logic [3:0] TYPE_FS  = 4'd3;
  localparam logic [3:0] TYPE_TC  = 4'd4;
  localparam logic [3:0] TYPE_RZ  = 4'd5;
  localparam logic [3:0] TYPE_LTS = 4'd6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    NEXT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/izh_state_table.sv
// Per-neuron state store: N_NEURONS entries of {v, u, type, I}.
//   clk, rst_n           : clock, synchronous active-low reset
//   rd_idx_i             : combinational read index (out of range reads 0)
//   rd_v_o/rd_u_o/...    : read data
//   wb_we_i/wb_idx_i/... : datapath writeback of v, u
//   type_we_i/cur_we_i   : host writes of type and input current at cfg_idx_i
// Writeback and config touch disjoint fields, so both may land in one cycle.
module izh_state_table #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned W         = 18,
  parameter int unsigned IDXW      = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IDXW-1:0] rd_idx_i,
  output logic [W-1:0]    rd_v_o,
  output logic [W-1:0]    rd_u_o,
  output logic [3:0]      rd_type_o,
  output logic [7:0]      rd_i_o,
  input  logic            wb_we_i,
  input  logic [IDXW-1:0] wb_idx_i,
  input  logic [W-1:0]    wb_v_i,
  input  logic [W-1:0]    wb_u_i,
  input  logic            type_we_i,
  input  logic            cur_we_i,
  input  logic [IDXW-1:0] cfg_idx_i,
  input  logic [3:0]      type_i,
  input  logic [7:0]      cur_i
);
  import izh_pkg::*;

  logic [W-1:0] v_q    [N_NEURONS];
  logic [W-1:0] u_q    [N_NEURONS];
  logic [3:0]   type_q [N_NEURONS];
  logic [7:0]   cur_q  [N_NEURONS];

  // Index decode by comparison keeps indices >= N_NEURONS harmless.
  always_comb begin
    rd_v_o    = '0;
    rd_u_o    = '0;
    rd_type_o = '0;
    rd_i_o    = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      if (rd_idx_i == IDXW'(k)) begin
        rd_v_o    = v_q[k];
        rd_u_o    = u_q[k];
        rd_type_o = type_q[k];
        rd_i_o    = cur_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      if (!rst_n) begin
        v_q[k]    <= W'(V_RST);
        u_q[k]    <= W'(U_RST);
        type_q[k] <= '0;
        cur_q[k]  <= '0;
      end else begin
        if (wb_we_i && (wb_idx_i == IDXW'(k))) begin
          v_q[k] <= wb_v_i;
          u_q[k] <= wb_u_i;
        end
        if (type_we_i && (cfg_idx_i == IDXW'(k))) type_q[k] <= type_i;
        if (cur_we_i && (cfg_idx_i == IDXW'(k)))  cur_q[k]  <= cur_i;
      end
    end
  end

endmodule

// File: rtl/izh_sweep_scheduler.sv
// Time-multiplexes one Izhikevich update datapath across N_NEURONS neurons.
//   clk, rst_n, ena, tick        : clock, sync active-low reset, sweep start
//   cfg_we/cur_we/cfg_idx/...    : host writes of type code and input current
//   dp_req/dp_idx/dp_v/dp_u/...  : registered operands to the datapath
//   dp_ack/dp_v_new/dp_u_new     : datapath result, written back on ack
//   dp_spike                     : datapath spike flag, qualified by dp_ack
//   spike_valid/spike_idx        : one-cycle spike event
//   busy/sweep_done/overrun      : sweep status; overrun is sticky
module izh_sweep_scheduler #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned W         = izh_pkg::W,
  parameter int unsigned IDXW      = $clog2(N_NEURONS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            tick,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [3:0]      cfg_type,
  input  logic            cur_we,
  input  logic [7:0]      cur_val,
  output logic            dp_req,
  output logic [IDXW-1:0] dp_idx,
  output logic [W-1:0]    dp_v,
  output logic [W-1:0]    dp_u,
  output logic [3:0]      dp_type,
  output logic [7:0]      dp_i,
  input  logic            dp_ack,
  input  logic [W-1:0]    dp_v_new,
  input  logic [W-1:0]    dp_u_new,
  input  logic            dp_spike,
  output logic            spike_valid,
  output logic [IDXW-1:0] spike_idx,
  output logic            busy,
  output logic            sweep_done,
  output logic            overrun
);
  import izh_pkg::*;

  state_e          state_q;
  logic            dp_req_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    dp_v_q;
  logic [W-1:0]    dp_u_q;
  logic [3:0]      dp_type_q;
  logic [7:0]      dp_i_q;
  logic            spike_valid_q;
  logic [IDXW-1:0] spike_idx_q;
  logic            busy_q;
  logic            sweep_done_q;
  logic            overrun_q;

  logic [IDXW-1:0] rd_idx;
  logic [W-1:0]    rd_v;
  logic [W-1:0]    rd_u;
  logic [3:0]      rd_type;
  logic [7:0]      rd_i;
  logic            wb_we;
  logic            last_idx;

  // The read port looks one step ahead: entry 0 while idle, idx+1 in NEXT,
  // so operand registers load on the same edge the state advances.
  assign rd_idx   = (state_q == NEXT) ? idx_q + IDXW'(1) : '0;
  assign wb_we    = (state_q == ISSUE) && dp_ack;
  assign last_idx = (idx_q == IDXW'(N_NEURONS - 1));

  izh_state_table #(
    .N_NEURONS (N_NEURONS),
    .W         (W),
    .IDXW      (IDXW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (rd_idx),
    .rd_v_o    (rd_v),
    .rd_u_o    (rd_u),
    .rd_type_o (rd_type),
    .rd_i_o    (rd_i),
    .wb_we_i   (wb_we),
    .wb_idx_i  (idx_q),
    .wb_v_i    (dp_v_new),
    .wb_u_i    (dp_u_new),
    .type_we_i (cfg_we),
    .cur_we_i  (cur_we),
    .cfg_idx_i (cfg_idx),
    .type_i    (cfg_type),
    .cur_i     (cur_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      dp_req_q      <= 1'b0;
      idx_q         <= '0;
      dp_v_q        <= '0;
      dp_u_q        <= '0;
      dp_type_q     <= '0;
      dp_i_q        <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      spike_valid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick && ena) begin
            state_q   <= ISSUE;
            idx_q     <= '0;
            dp_v_q    <= rd_v;
            dp_u_q    <= rd_u;
            dp_type_q <= rd_type;
            dp_i_q    <= rd_i;
            dp_req_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ISSUE: begin
          if (dp_ack) begin
            dp_req_q <= 1'b0;
            if (dp_spike) begin
              spike_valid_q <= 1'b1;
              spike_idx_q   <= idx_q;
            end
            if (last_idx) begin
              state_q      <= DONE;
              sweep_done_q <= 1'b1;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
          state_q   <= ISSUE;
          idx_q     <= idx_q + IDXW'(1);
          dp_v_q    <= rd_v;
          dp_u_q    <= rd_u;
          dp_type_q <= rd_type;
          dp_i_q    <= rd_i;
          dp_req_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dp_req      = dp_req_q;
  assign dp_idx      = idx_q;
  assign dp_v        = dp_v_q;
  assign dp_u        = dp_u_q;
  assign dp_type     = dp_type_q;
  assign dp_i        = dp_i_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign busy        = busy_q;
  assign sweep_done  = sweep_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_izh_sweep_scheduler.sv
// Scoreboard bench for izh_sweep_scheduler (N_NEURONS=4 main instance,
// N_NEURONS=5 instance for out-of-range config writes).
module tb_izh_sweep_scheduler;

  localparam logic [17:0] V0 = 18'h3_4CCD;
  localparam logic [17:0] U0 = 18'h3_CCCD;

  typedef struct packed {
    logic [1:0]  idx;
    logic [17:0] v;
    logic [17:0] u;
    logic [3:0]  t;
    logic [7:0]  i;
  } issue_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned ec = 0;
  always @(posedge clk) ec <= ec + 1;

  // main DUT signals
  logic        rst_n, ena, tick, cfg_we, cur_we;
  logic [1:0]  cfg_idx;
  logic [3:0]  cfg_type;
  logic [7:0]  cur_val;
  logic        dp_req, dp_ack, dp_spike, spike_valid, busy, sweep_done, overrun;
  logic [1:0]  dp_idx, spike_idx;
  logic [17:0] dp_v, dp_u, dp_v_new, dp_u_new;
  logic [3:0]  dp_type;
  logic [7:0]  dp_i;

  // datapath model: ack after ack_delay waiting cycles, returns v+1/u+1
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  logic        spike_en  = 1'b0;
  logic [1:0]  spike_tgt = 2'd0;
  assign dp_ack   = dp_req && (wait_cnt == ack_delay);
  assign dp_v_new = dp_v + 18'd1;
  assign dp_u_new = dp_u + 18'd1;
  assign dp_spike = spike_en && dp_ack && (dp_idx == spike_tgt);
  always @(posedge clk) begin
    if (dp_req && !dp_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  izh_sweep_scheduler #(.N_NEURONS(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_type(cfg_type),
    .cur_we(cur_we), .cur_val(cur_val),
    .dp_req(dp_req), .dp_idx(dp_idx), .dp_v(dp_v), .dp_u(dp_u),
    .dp_type(dp_type), .dp_i(dp_i), .dp_ack(dp_ack),
    .dp_v_new(dp_v_new), .dp_u_new(dp_u_new), .dp_spike(dp_spike),
    .spike_valid(spike_valid), .spike_idx(spike_idx),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  // second instance with a non power-of-two neuron count
  logic        ena5, tick5, cfg_we5, cur_we5;
  logic [2:0]  cfg_idx5, dp_idx5, spike_idx5;
  logic [3:0]  cfg_type5, dp_type5;
  logic [7:0]  cur_val5, dp_i5;
  logic        dp_req5, spike_valid5, busy5, sweep_done5, overrun5;
  logic [17:0] dp_v5, dp_u5, dp_v_new5, dp_u_new5;
  logic        dp_ack5;
  assign dp_ack5   = dp_req5;
  assign dp_v_new5 = dp_v5 + 18'd1;
  assign dp_u_new5 = dp_u5 + 18'd1;

  izh_sweep_scheduler #(.N_NEURONS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .ena(ena5), .tick(tick5),
    .cfg_we(cfg_we5), .cfg_idx(cfg_idx5), .cfg_type(cfg_type5),
    .cur_we(cur_we5), .cur_val(cur_val5),
    .dp_req(dp_req5), .dp_idx(dp_idx5), .dp_v(dp_v5), .dp_u(dp_u5),
    .dp_type(dp_type5), .dp_i(dp_i5), .dp_ack(dp_ack5),
    .dp_v_new(dp_v_new5), .dp_u_new(dp_u_new5), .dp_spike(1'b0),
    .spike_valid(spike_valid5), .spike_idx(spike_idx5),
    .busy(busy5), .sweep_done(sweep_done5), .overrun(overrun5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard state
  issue_t      iq[$];
  int unsigned dq[$];
  logic [1:0]  sq[$];
  logic [17:0] mv [4];
  logic [17:0] mu [4];
  logic [3:0]  mt [4];
  logic [7:0]  mi [4];

  issue_t cur;
  logic   req_prev  = 1'b0;
  logic   done_prev = 1'b0;

  always @(negedge clk) begin
    if (dp_req === 1'b1) begin
      if (!req_prev) begin
        if (iq.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          cur = iq.pop_front();
          check("issue_idx",  32'(dp_idx),  32'(cur.idx));
          check("issue_v",    32'(dp_v),    32'(cur.v));
          check("issue_u",    32'(dp_u),    32'(cur.u));
          check("issue_type", 32'(dp_type), 32'(cur.t));
          check("issue_i",    32'(dp_i),    32'(cur.i));
        end
      end else begin
        check("hold_idx",  32'(dp_idx),  32'(cur.idx));
        check("hold_v",    32'(dp_v),    32'(cur.v));
        check("hold_u",    32'(dp_u),    32'(cur.u));
        check("hold_type", 32'(dp_type), 32'(cur.t));
        check("hold_i",    32'(dp_i),    32'(cur.i));
      end
    end
    req_prev = (dp_req === 1'b1);

    if (spike_valid === 1'b1) begin
      if (sq.size() == 0) check("unexpected_spike", 32'd1, 32'd0);
      else check("spike_idx", 32'(spike_idx), 32'(sq.pop_front()));
    end

    if (done_prev) check("busy_after_done", 32'(busy), 32'd0);
    if (sweep_done === 1'b1) begin
      check("busy_in_done", 32'(busy), 32'd1);
      if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("done_cycle", ec, dq.pop_front());
    end
    done_prev = (sweep_done === 1'b1);
  end

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mv[k] = V0; mu[k] = U0; mt[k] = 4'd0; mi[k] = 8'd0;
    end
  endtask

  task automatic start_sweep(input int unsigned d);
    issue_t r;
    @(negedge clk);
    ack_delay = d;
    for (int k = 0; k < 4; k++) begin
      r.idx = 2'(k); r.v = mv[k]; r.u = mu[k]; r.t = mt[k]; r.i = mi[k];
      iq.push_back(r);
      mv[k] = mv[k] + 18'd1;
      mu[k] = mu[k] + 18'd1;
    end
    dq.push_back(ec + 4 * (d + 2));
    ena  = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    check("issues_consumed", iq.size(), 32'd0);
    check("done_consumed", dq.size(), 32'd0);
  endtask

  task automatic wait_issue(input logic [1:0] idx, input string tag);
    int unsigned n = 0;
    while (!(dp_req && dp_idx == idx) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dp_req && dp_idx == idx), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned seen5;
    rst_n = 1'b0; ena = 1'b0; tick = 1'b0; cfg_we = 1'b0; cur_we = 1'b0;
    cfg_idx = '0; cfg_type = '0; cur_val = '0;
    ena5 = 1'b0; tick5 = 1'b0; cfg_we5 = 1'b0; cur_we5 = 1'b0;
    cfg_idx5 = '0; cfg_type5 = '0; cur_val5 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dp_req",      32'(dp_req),      32'd0);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_sweep_done",  32'(sweep_done),  32'd0);
    check("rst_spike_valid", 32'(spike_valid), 32'd0);
    check("rst_overrun",     32'(overrun),     32'd0);
    rst_n = 1'b1;

    // tick with ena low is ignored
    @(negedge clk); ena = 1'b0; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
    check("ena_low_busy", 32'(busy), 32'd0);
    check("ena_low_overrun", 32'(overrun), 32'd0);

    // immediate ack: two sweeps, second sees v+1
    start_sweep(0); wait_idle("sweep1_idle");
    start_sweep(0); wait_idle("sweep2_idle");

    // ack delayed 3 cycles, ena dropped mid-sweep
    start_sweep(3);
    ena = 1'b0;
    wait_idle("delayed_idle");

    // spike on idx 2 only
    spike_en = 1'b1; spike_tgt = 2'd2; sq.push_back(2'd2);
    start_sweep(0); wait_idle("spike_idle");
    spike_en = 1'b0;
    check("spike_consumed", sq.size(), 32'd0);

    // ticks during ISSUE and during DONE
    start_sweep(0);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("overrun_issue", 32'(overrun), 32'd1);
    n = 0;
    while (!sweep_done && n < 50) begin @(negedge clk); n++; end
    check("overrun_reach_done", 32'(sweep_done), 32'd1);
    tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (10) @(negedge clk);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("overrun_no_sweep", 32'(busy), 32'd0);
    check("overrun_done_consumed", dq.size(), 32'd0);

    // config write while idx 1 in flight
    start_sweep(3);
    wait_issue(2'd1, "cfg_reach_idx1");
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_type = 4'd3;
    cur_we = 1'b1; cur_val = 8'h10;
    @(negedge clk);
    cfg_we = 1'b0; cur_we = 1'b0;
    wait_idle("cfg_idle");
    mt[1] = 4'd3; mi[1] = 8'h10;
    start_sweep(0); wait_idle("cfg_next_idle");

    // reset mid-sweep at idx 2
    check("pre_rst_overrun", 32'(overrun), 32'd1);
    start_sweep(3);
    wait_issue(2'd2, "rst_reach_idx2");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dp_req",  32'(dp_req),  32'd0);
    check("midrst_busy",    32'(busy),    32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    iq.delete(); dq.delete();
    model_reset();
    start_sweep(0); wait_idle("post_rst_idle");

    // N_NEURONS=5: write to index 5 must be dropped, index 4 accepted
    @(negedge clk);
    cfg_we5 = 1'b1; cur_we5 = 1'b1; cfg_idx5 = 3'd5; cfg_type5 = 4'd7; cur_val5 = 8'h55;
    @(negedge clk);
    cfg_idx5 = 3'd4; cfg_type5 = 4'd2; cur_val5 = 8'h07;
    @(negedge clk);
    cfg_we5 = 1'b0; cur_we5 = 1'b0; ena5 = 1'b1; tick5 = 1'b1;
    @(negedge clk);
    tick5 = 1'b0;
    seen5 = 0;
    for (int c = 0; c < 30; c++) begin
      if (dp_req5) begin
        check("n5_idx",  32'(dp_idx5),  seen5);
        check("n5_v",    32'(dp_v5),    32'(V0));
        check("n5_type", 32'(dp_type5), (seen5 == 4) ? 32'd2 : 32'd0);
        check("n5_i",    32'(dp_i5),    (seen5 == 4) ? 32'h07 : 32'd0);
        seen5++;
      end
      @(negedge clk);
    end
    check("n5_issue_count", seen5, 32'd5);
    check("n5_busy", 32'(busy5), 32'd0);

    check("final_issues", iq.size(), 32'd0);
    check("final_spikes", sq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
